// File: rtl/stopwatch_bcd_counter.sv
`timescale 1ns/1ps
// Purpose: debounced start/pause/clear stopwatch counting SS.hh in packed BCD for the 4-digit display.
// Latency: button press acts 2 sync + DB_CYCLES + 1 cycles after the raw edge; bcd_out updates the cycle after tick.
// Backpressure: none; free-running source, display samples bcd_out whenever it likes.
// Optional lap hold is compiled in with `define LAP_HOLD_EN.
module stopwatch_bcd_counter #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] bcd_out,
    output logic        running,
    output logic        wrap_pulse
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);
    localparam int DW  = $clog2(DB_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

`ifdef LAP_HOLD_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    // button index 0 = start, 1 = clear, 2 = lap (lap only with hold feature)
    logic [NB-1:0] btn_raw;
`ifdef LAP_HOLD_EN
    assign btn_raw = {btn_lap, btn_clear, btn_start};
`else
    logic unused_lap;
    assign unused_lap = btn_lap;
    assign btn_raw    = {btn_clear, btn_start};
`endif

    logic [NB-1:0]         sync1;
    logic [NB-1:0]         sync2;
    logic [NB-1:0]         db_lvl;
    logic [NB-1:0]         press;
    logic [NB-1:0][DW-1:0] db_cnt;

    // synchronize raw buttons, accept a level after DB_CYCLES identical samples, pulse on accepted rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= '0;
            sync2  <= '0;
            db_lvl <= '0;
            press  <= '0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < NB; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic start_p;
    logic clear_p;
    assign start_p = press[0];
    assign clear_p = press[1];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // next state: clear overrides a coincident start
    always_comb begin
        state_nx = state;
        if (clear_p) begin
            state_nx = IDLE;
        end else if (start_p) begin
            case (state)
                IDLE:    state_nx = RUN;
                RUN:     state_nx = PAUSE;
                PAUSE:   state_nx = RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    // state register with running registered alongside it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_nx;
            running <= (state_nx == RUN);
        end
    end

    logic [PW-1:0] presc;
    logic          tick;
    assign tick = (state == RUN) && (presc == TERM);

    // prescaler only moves in RUN so a pause keeps the partial tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (clear_p) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    logic [15:0] count;
    logic [15:0] count_inc;
    logic        at_max;
    assign at_max = (count == 16'h5999);

    // BCD increment with full carry ripple; seconds tens wraps at 5
    always_comb begin
        count_inc = count;
        if (count[3:0] != 4'd9) begin
            count_inc[3:0] = count[3:0] + 4'd1;
        end else begin
            count_inc[3:0] = 4'd0;
            if (count[7:4] != 4'd9) begin
                count_inc[7:4] = count[7:4] + 4'd1;
            end else begin
                count_inc[7:4] = 4'd0;
                if (count[11:8] != 4'd9) begin
                    count_inc[11:8] = count[11:8] + 4'd1;
                end else begin
                    count_inc[11:8]  = 4'd0;
                    count_inc[15:12] = (count[15:12] == 4'd5) ? 4'd0 : count[15:12] + 4'd1;
                end
            end
        end
    end

    // live count register and rollover strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= 16'h0000;
            wrap_pulse <= 1'b0;
        end else if (clear_p) begin
            count      <= 16'h0000;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= tick && at_max;
            if (tick) begin
                count <= count_inc;
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic        hold;
    logic [15:0] lap_cap;

    // lap press in RUN toggles the hold; capture happens on the engaging press
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold    <= 1'b0;
            lap_cap <= 16'h0000;
        end else if (clear_p) begin
            hold <= 1'b0;
        end else if (press[2] && (state == RUN)) begin
            hold <= !hold;
            if (!hold) begin
                lap_cap <= count;
            end
        end
    end

    assign bcd_out = hold ? lap_cap : count;
`else
    assign bcd_out = count;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
`timescale 1ns/1ps
// Bench for stopwatch_bcd_counter at CLK_HZ=1000, TICK_HZ=100, DB_CYCLES=4.
// An integer-time model predicts every output each cycle; directed checks pin key values.
// Define LAP_HOLD_EN for both files to exercise the lap hold.
module tb_stopwatch_bcd_counter;

    localparam int DB  = 4;
    localparam int DIV = 10;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        btn_start = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_lap   = 1'b0;
    logic [15:0] bcd_out;
    logic        running;
    logic        wrap_pulse;

    int checks = 0;
    int errors = 0;

    stopwatch_bcd_counter #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .DB_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .bcd_out   (bcd_out),
        .running   (running),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // model: elapsed time as integer hundredths, state 0=idle 1=run 2=pause
    int          m_state = 0;
    int          m_presc = 0;
    int          m_cnt   = 0;
    int          m_cap   = 0;
    bit          m_hold  = 0;
    bit          m_wrap  = 0;
    logic [2:0]  r1 = '0, r2 = '0, acc = '0, pend = '0;
    logic [2:0]  raw, newp, s;
    logic [DB-1:0] hist [3];
    int          pre_cnt;
    bit          was_run;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_presc = 0; m_cnt = 0; m_cap = 0;
            m_hold = 0; m_wrap = 0;
            r1 = '0; r2 = '0; acc = '0; pend = '0;
            for (int b = 0; b < 3; b++) hist[b] = '0;
        end else begin
            raw     = {btn_lap, btn_clear, btn_start};
            was_run = (m_state == 1);
            pre_cnt = m_cnt;
            if (pend[1]) begin
                m_state = 0; m_cnt = 0; m_presc = 0; m_wrap = 0; m_hold = 0;
            end else begin
                m_wrap = 0;
`ifdef LAP_HOLD_EN
                if (pend[2] && was_run) begin
                    if (!m_hold) m_cap = pre_cnt;
                    m_hold = !m_hold;
                end
`endif
                if (was_run) begin
                    if (m_presc == DIV - 1) begin
                        m_presc = 0;
                        m_wrap  = (m_cnt == 5999);
                        m_cnt   = (m_cnt + 1) % 6000;
                    end else begin
                        m_presc++;
                    end
                end
                if (pend[0]) m_state = (m_state == 1) ? 2 : 1;
            end
            // a level is accepted once the last DB synchronized samples all agree on a new value
            s  = r2;
            r2 = r1;
            r1 = raw;
            newp = '0;
            for (int b = 0; b < 3; b++) begin
                hist[b] = {hist[b][DB-2:0], s[b]};
                if ((hist[b] == {DB{s[b]}}) && (s[b] != acc[b])) begin
                    acc[b]  = s[b];
                    newp[b] = s[b];
                end
            end
            pend = newp;
        end
    end

    always @(negedge clk) begin
        check("bcd_out", bcd_out, to_bcd(m_hold ? m_cap : m_cnt));
        check("running", {15'd0, running}, {15'd0, m_state == 1});
        check("wrap_pulse", {15'd0, wrap_pulse}, {15'd0, m_wrap});
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end

    initial begin
        #1 reset = 1'b0;
        #30;
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_running", {15'd0, running}, 16'h0000);
        check("rst_wrap", {15'd0, wrap_pulse}, 16'h0000);
        reset = 1'b1;
        @(posedge clk); #2;

        // start press held long: runs once, never pauses
        btn_start = 1'b1;
        wait_cyc(6);
        check("start_c6", {15'd0, running}, 16'h0000);
        wait_cyc(1);
        check("start_c7", {15'd0, running}, 16'h0001);
        wait_cyc(1229);
        check("cnt_0122", bcd_out, 16'h0122);
        wait_cyc(1);
        check("cnt_0123", bcd_out, 16'h0123);
        check("held_running", {15'd0, running}, 16'h0001);
        btn_start = 1'b0;
        wait_cyc(2190);
        check("cnt_0342", bcd_out, 16'h0342);
        wait_cyc(4);

        // asynchronous reset mid-run
        #1 reset = 1'b0;
        #1;
        check("async_bcd", bcd_out, 16'h0000);
        check("async_running", {15'd0, running}, 16'h0000);
        check("async_wrap", {15'd0, wrap_pulse}, 16'h0000);
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #2;

        // glitch shorter than the debounce window
        btn_start = 1'b1;
        wait_cyc(3);
        btn_start = 1'b0;
        wait_cyc(20);
        check("glitch_running", {15'd0, running}, 16'h0000);
        check("glitch_bcd", bcd_out, 16'h0000);

        // run to 02.50 plus three prescaler counts, then pause
        btn_start = 1'b1;
        wait_cyc(8);
        btn_start = 1'b0;
        wait_cyc(2495);
        btn_start = 1'b1;
        wait_cyc(7);
        check("pause_running", {15'd0, running}, 16'h0000);
        check("pause_bcd", bcd_out, 16'h0250);
        wait_cyc(1);
        btn_start = 1'b0;
        wait_cyc(500);
        check("pause_hold", bcd_out, 16'h0250);

        // resume: saved fraction means first increment 7 cycles after running rises
        btn_start = 1'b1;
        wait_cyc(7);
        check("resume_running", {15'd0, running}, 16'h0001);
        btn_start = 1'b0;
        wait_cyc(6);
        check("resume_c6", bcd_out, 16'h0250);
        wait_cyc(1);
        check("resume_c7", bcd_out, 16'h0251);

        // rollover 59.98 -> 59.99 -> 00.00
        wait_cyc(57470);
        check("cnt_5998", bcd_out, 16'h5998);
        wait_cyc(10);
        check("cnt_5999", bcd_out, 16'h5999);
        check("no_wrap_yet", {15'd0, wrap_pulse}, 16'h0000);
        wait_cyc(10);
        check("wrap_bcd", bcd_out, 16'h0000);
        check("wrap_pulse", {15'd0, wrap_pulse}, 16'h0001);
        check("wrap_running", {15'd0, running}, 16'h0001);
        wait_cyc(1);
        check("wrap_one_cycle", {15'd0, wrap_pulse}, 16'h0000);
        check("wrap_still_run", {15'd0, running}, 16'h0001);

        // clear and start accepted together: clear wins
        btn_start = 1'b1;
        btn_clear = 1'b1;
        wait_cyc(6);
        check("both_c6", {15'd0, running}, 16'h0001);
        wait_cyc(1);
        check("both_running", {15'd0, running}, 16'h0000);
        check("both_bcd", bcd_out, 16'h0000);
        wait_cyc(2);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        wait_cyc(10);
        check("clear_idle", {15'd0, running}, 16'h0000);

`ifdef LAP_HOLD_EN
        // lap at 01.00, hold 200 cycles, release to live 01.20
        btn_start = 1'b1;
        wait_cyc(8);
        btn_start = 1'b0;
        wait_cyc(995);
        btn_lap = 1'b1;
        wait_cyc(7);
        check("lap_cap", bcd_out, 16'h0100);
        btn_lap = 1'b0;
        wait_cyc(192);
        check("lap_held", bcd_out, 16'h0100);
        wait_cyc(1);
        btn_lap = 1'b1;
        wait_cyc(6);
        check("lap_last_held", bcd_out, 16'h0100);
        wait_cyc(1);
        check("lap_live", bcd_out, 16'h0120);
        btn_lap = 1'b0;
        wait_cyc(10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
